normalizer: RTL and testbench
=============================

# normalizer

Multi-cycle left-normalizer for the datapath: it does the inverse of the shift unit. The shift unit takes an operand and a shift amount and produces shifted data. This block takes an operand and finds the shift amount that normalizes it, returning both the normalized value and the count. Normalization is either unsigned (MSB set) or signed (sign bit differs from the next bit). It sits beside the ALU and shifter and serves count-leading-zeros/sign instructions and software floating-point helpers through a start/done handshake.

## Interface
- WIDTH, 16, operand width in bits
- CNT_W, 5, count width; must hold WIDTH-1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- data  input  WIDTH  operand, sampled with start
- mode  input  1  0 = unsigned normalize, 1 = signed normalize; sampled with start
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; result, count and zero are valid
- result  output  WIDTH  normalized operand, held until the next done
- count  output  CNT_W  number of left shifts applied, held until the next done
- zero  output  1  operand was zero-class; held until the next done

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=0: remain in IDLE.
- IDLE, start=1, operand not zero-class:
  - Load the work register with data and clear the shift counter.
  - Latch mode.
  - Go to SHIFT.
- IDLE, start=1, operand zero-class:
  - Zero-class is data==0 in unsigned mode, or data==0 or data==all-ones in signed mode.
  - result=data, count=0, zero=1.
  - Go directly to DONE.
- SHIFT, each cycle, test the terminal condition on the work register:
  - Unsigned: work[WIDTH-1]==1.
  - Signed: work[WIDTH-1]!=work[WIDTH-2].
  - If met: result=work, count=counter, zero=0; go to DONE.
  - Otherwise: work <= work<<1 with zero fill, counter += 1.
- Shift bounds: unsigned needs at most WIDTH-1 shifts, signed at most WIDTH-2. The zero-class pre-check guarantees termination, so the counter never wraps.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored while busy=1 (SHIFT or DONE); no queuing.
- A new operation does not alter result, count or zero until its own DONE.
- Reset, asynchronous at any time, including mid-operation:
  - State goes to IDLE and the in-flight operation is discarded.
  - busy, done, result, count and zero all go to 0.

## Timing
- E0 is the rising edge that samples start=1 in IDLE.
- Non-zero-class operand: the SHIFT test runs on edges E1..E(count+1), and done is high in the cycle after E(count+1). Latency is count+2 edges from E0 to the end of the done cycle; worst case (unsigned 0x0001) is 16 SHIFT edges.
- Zero-class operand: done is high in the cycle after E0.
- busy rises in the cycle after E0 and falls in the cycle after done.
- The earliest next accepted start is the first edge on which the state is IDLE, i.e. the edge that ends the done cycle plus one.
- result, count and zero update on the same edge that raises done and are stable while done=1.

## Test plan
- Unsigned, data=0x0001 → done after E16, result=0x8000, count=15, zero=0.
- Unsigned, data=0x8000 → done after E1, result=0x8000, count=0; next start=1 with data=0x00F0 → result=0xF000, count=8.
- Signed:
  - data=0xFFF0 → result=0x8000, count=11.
  - data=0x0003 → result=0x6000, count=13.
  - data=0x4000 → result=0x4000, count=0.
- Zero-class:
  - Unsigned 0x0000 → done after E0, result=0x0000, count=0, zero=1.
  - Signed 0xFFFF → result=0xFFFF, count=0, zero=1.
  - Unsigned 0xFFFF is not zero-class → count=0, zero=0.
- Start held high throughout an unsigned 0x0001 operation with data changing each cycle → only the first operand is processed, and a second operation begins only after return to IDLE.
- rst_n pulsed low during SHIFT of 0x0001 → immediately busy=0, done=0, result=0, count=0, zero=0, and no done pulse follows. A subsequent start with 0x0100 → result=0x8000, count=7.

Source files
------------

// File: rtl/normalizer.sv
`default_nettype none
// ============================================================================
// Module   : normalizer
// Purpose  : Multi-cycle left-normalizer. Finds the number of left shifts
//            that normalize an operand (unsigned: MSB set; signed: sign bit
//            differs from the next bit). Returns the normalized value and the
//            shift count through a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module normalizer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_count;
  logic             r_zero;
  logic             w_zero_class;
  logic             w_term;

  // Operands that never normalize are caught up front, so SHIFT always ends.
  assign w_zero_class = (data == '0) || (mode && (data == '1));

  // Terminal test on the work register, using the mode latched at start.
  assign w_term = r_mode ? (r_work[WIDTH-1] ^ r_work[WIDTH-2]) : r_work[WIDTH-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_zero_class ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_term) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Work register, shift counter and the held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_result <= '0;
      r_count  <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero_class) begin
              r_result <= data;
              r_count  <= '0;
              r_zero   <= 1'b1;
            end else begin
              r_work <= data;
              r_cnt  <= '0;
              r_mode <= mode;
            end
          end
        end
        S_SHIFT: begin
          if (w_term) begin
            r_result <= r_work;
            r_count  <= r_cnt;
            r_zero   <= 1'b0;
          end else begin
            r_work <= r_work << 1;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign count  = r_count;
  assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_normalizer
// Purpose  : Self-checking bench for normalizer: directed vector table,
//            hand-written multi-cycle sequences and randomized operands
//            checked against a leading-bit-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_normalizer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data;
  logic        mode;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [4:0]  count;
  logic        zero;

  int checks;
  int failures;
  logic [15:0] prev_result;

  normalizer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (data),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .result(result),
    .count (count),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [15:0] d;
    logic [15:0] r;
    int          c;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count redundant leading bits directly from the operand.
  function automatic void model(input logic m, input logic [15:0] d,
                                output logic [15:0] r, output int c, output logic z);
    int msb;
    if (d == 16'h0000 || (m && d == 16'hFFFF)) begin
      r = d; c = 0; z = 1'b1;
      return;
    end
    z = 1'b0;
    msb = 0;
    if (!m) begin
      for (int i = 0; i < 16; i++) if (d[i]) msb = i;
      c = 15 - msb;
    end else begin
      for (int i = 0; i < 15; i++) if (d[i] != d[15]) msb = i;
      c = 14 - msb;
    end
    r = d << c;
  endfunction

  // One complete operation starting from IDLE, with latency and hold checks.
  task automatic run_op(input logic m, input logic [15:0] d, input logic [15:0] er,
                        input int ec, input logic ez, input string tag);
    int n;
    int exp_lat;
    exp_lat = ez ? 0 : ec + 1;
    @(negedge clk);
    start = 1'b1; data = d; mode = m;
    @(posedge clk); #1;
    start = 1'b0; data = $urandom; mode = $urandom;
    if (!ez) chk({tag, "_hold_result"}, result, prev_result);
    chk({tag, "_busy_after_e0"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_result"}, result, er);
    chk({tag, "_count"}, count, ec);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_busy_in_done"}, busy, 1);
    prev_result = er;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_result_held"}, result, er);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    int seen;
    logic [15:0] r_m;
    int c_m;
    logic z_m;
    logic m_r;
    logic [15:0] d_r;

    checks = 0;
    failures = 0;
    prev_result = 16'h0000;

    vecs[0] = '{1'b0, 16'h0001, 16'h8000, 15, 1'b0};
    vecs[1] = '{1'b0, 16'h8000, 16'h8000, 0,  1'b0};
    vecs[2] = '{1'b0, 16'h00F0, 16'hF000, 8,  1'b0};
    vecs[3] = '{1'b1, 16'hFFF0, 16'h8000, 11, 1'b0};
    vecs[4] = '{1'b1, 16'h0003, 16'h6000, 13, 1'b0};
    vecs[5] = '{1'b1, 16'h4000, 16'h4000, 0,  1'b0};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 0,  1'b1};
    vecs[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 0,  1'b1};
    vecs[8] = '{1'b0, 16'hFFFF, 16'hFFFF, 0,  1'b0};
    vecs[9] = '{1'b1, 16'h0000, 16'h0000, 0,  1'b1};

    rst_n = 1'b0; start = 1'b0; data = 16'h0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_count", count, 0);
    chk("reset_zero", zero, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table, applied back-to-back at the earliest accepted start.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].m, vecs[i].d, vecs[i].r, vecs[i].c, vecs[i].z, $sformatf("vec%0d", i));
    end

    // Start held high with data changing: only the first operand is taken.
    @(negedge clk); mode = 1'b0; start = 1'b1; data = 16'h0001;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk); data = 16'h0001 | 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("hold_latency", n, 16);
    chk("hold_result", result, 16'h8000);
    chk("hold_count", count, 15);
    @(negedge clk); data = 16'($urandom) | 16'h0001;
    @(posedge clk); #1;
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_done", done, 0);
    @(negedge clk); data = 16'h00F0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_second_accepted", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold2_latency", n, 9);
    chk("hold2_result", result, 16'hF000);
    chk("hold2_count", count, 8);
    prev_result = 16'hF000;
    @(posedge clk); #1;

    // Asynchronous reset mid-SHIFT discards the operation.
    @(negedge clk); mode = 1'b0; start = 1'b1; data = 16'h0001;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_count", count, 0);
    chk("arst_zero", zero, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("arst_no_done", seen, 0);
    prev_result = 16'h0000;
    run_op(1'b0, 16'h0100, 16'h8000, 7, 1'b0, "post_rst");

    // Randomized operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      m_r = 1'($urandom);
      case ($urandom_range(0, 7))
        0: d_r = 16'h0000;
        1: d_r = 16'hFFFF;
        2: d_r = 16'h0001 << $urandom_range(0, 15);
        default: d_r = 16'($urandom) >> $urandom_range(0, 15);
      endcase
      model(m_r, d_r, r_m, c_m, z_m);
      run_op(m_r, d_r, r_m, c_m, z_m, $sformatf("rnd%0d_m%0d_d%04h", i, m_r, d_r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
